// File: rtl/edge_pkg.sv
// Shared encodings for the edge_pulse_array input conditioner.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'b00,
    RPT_DELAY  = 2'b01,
    RPT_REPEAT = 2'b10
  } rpt_state_e;

endpackage

// File: rtl/edge_pulse_array_if.sv
// Raw inputs, per-channel mode select and conditioned outputs of edge_pulse_array.
interface edge_pulse_array_if #(
  parameter int unsigned CHANNELS = 5
) ();

  logic [CHANNELS-1:0]   in_raw;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   pulse;
  logic                  any_pulse;

  modport master (output in_raw, mode, input level, pulse, any_pulse);
  modport slave  (input in_raw, mode, output level, pulse, any_pulse);

endinterface

// File: rtl/edge_channel.sv
// One input channel: 2-FF synchroniser, debounce, edge select and optional
// hold-to-repeat (compiled in when AUTOREPEAT_EN is defined).
module edge_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_raw,
  input  logic [1:0] i_mode,
  output logic       o_level,
  output logic       o_pulse
);
  import edge_pkg::*;

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_s1, r_s2, r_level, r_pulse;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_rise, w_fall, w_edge_pulse, w_pulse_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_pulse <= w_pulse_nxt;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Edge acceptance and mode-qualified edge pulse
  always_comb begin
    w_accept     = (r_s2 != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    w_rise       = w_accept & r_s2;
    w_fall       = w_accept & ~r_s2;
    w_edge_pulse = 1'b0;
    case (i_mode)
      EDGE_RISE: w_edge_pulse = w_rise;
      EDGE_FALL: w_edge_pulse = w_fall;
      EDGE_BOTH: w_edge_pulse = w_accept;
      default:   w_edge_pulse = 1'b0;
    endcase
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  rpt_state_e    r_state, w_state_nxt;
  logic [RW-1:0] r_rcnt, w_rcnt_nxt;
  logic          w_exit, w_rpt_pulse;

  // Release (level falling now or already low) or leaving rise mode ends repeating
  assign w_exit = (i_mode != EDGE_RISE) || !r_level || w_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RPT_IDLE;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RPT_IDLE:   if (w_rise && (i_mode == EDGE_RISE)) w_state_nxt = RPT_DELAY;
      RPT_DELAY: begin
        if (w_exit)                                    w_state_nxt = RPT_IDLE;
        else if (r_rcnt == RW'(REPEAT_DELAY - 1))      w_state_nxt = RPT_REPEAT;
      end
      RPT_REPEAT: if (w_exit)                          w_state_nxt = RPT_IDLE;
      default:                                         w_state_nxt = RPT_IDLE;
    endcase
  end

  always_comb begin
    w_rcnt_nxt  = r_rcnt + RW'(1);
    w_rpt_pulse = 1'b0;
    case (r_state)
      RPT_DELAY: begin
        if (w_exit) begin
          w_rcnt_nxt = '0;
        end else if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
          w_rcnt_nxt  = '0;
          w_rpt_pulse = 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (w_exit) begin
          w_rcnt_nxt = '0;
        end else if (r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
          w_rcnt_nxt  = '0;
          w_rpt_pulse = 1'b1;
        end
      end
      default: w_rcnt_nxt = '0;
    endcase
  end

  assign w_pulse_nxt = w_edge_pulse | w_rpt_pulse;
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_pulse_nxt  = w_edge_pulse;
`endif

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/edge_pulse_array.sv
// Multi-channel button/switch conditioner; optional hold-to-repeat via AUTOREPEAT_EN.
module edge_pulse_array #(
  parameter int unsigned CHANNELS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input logic          clk,
  input logic          rst,
  edge_pulse_array_if.slave bus
);

  logic [CHANNELS-1:0] w_level, w_pulse;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    edge_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (bus.in_raw[gi]),
      .i_mode  (bus.mode[2*gi +: 2]),
      .o_level (w_level[gi]),
      .o_pulse (w_pulse[gi])
    );
  end

  assign bus.level     = w_level;
  assign bus.pulse     = w_pulse;
  assign bus.any_pulse = |w_pulse;

endmodule

// File: tb/tb_edge_pulse_array.sv
// Self-checking bench for edge_pulse_array: vector table plus corner sequences,
// expected pulses/levels queued at drive time and checked every cycle.
module tb_edge_pulse_array;

  localparam int unsigned CH  = 5;
  localparam int unsigned DB  = 4;
  localparam int unsigned RD  = 8;
  localparam int unsigned RP  = 4;
  localparam int          LAT = 2 + DB;  // drive at negedge -> visible after this many edges

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_pulse_array_if #(.CHANNELS(CH)) bus ();

  edge_pulse_array #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int   due;
    int   ch;
    logic lvl;
    logic pul;
  } exp_t;

  typedef struct {
    int         ch;
    logic [1:0] mode;
    logic       val;
    logic       pul;
  } vec_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic drive(input int ch, input logic [1:0] m, input logic v, input logic p);
    bus.mode[2*ch +: 2] = m;
    bus.in_raw[ch]      = v;
    q.push_back('{cyc + LAT, ch, v, p});
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle monitor: pops items due now and compares the whole output bus
  initial begin : monitor
    logic [CH-1:0] exp_p;
    logic [CH-1:0] exp_l;
    logic          rst_edge;
    exp_l = '0;
    forever begin
      @(posedge clk);
      rst_edge = rst;
      cyc++;
      #1;
      exp_p = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == cyc) begin
          exp_p[q[i].ch] = exp_p[q[i].ch] | q[i].pul;
          exp_l[q[i].ch] = q[i].lvl;
          q.delete(i);
        end
      end
      if (rst_edge) begin
        exp_p = '0;
        exp_l = '0;
      end
      chk("pulse", 32'(bus.pulse), 32'(exp_p));
      chk("any_pulse", 32'(bus.any_pulse), 32'(|exp_p));
      chk("level", 32'(bus.level), 32'(exp_l));
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[13];
    int   t;
    vecs[0]  = '{0, 2'b00, 1'b1, 1'b1};  // clean rise
    vecs[1]  = '{0, 2'b00, 1'b0, 1'b0};  // release: repeat due on the exit edge is suppressed
    vecs[2]  = '{2, 2'b01, 1'b1, 1'b0};
    vecs[3]  = '{2, 2'b01, 1'b0, 1'b1};
    vecs[4]  = '{3, 2'b10, 1'b1, 1'b1};
    vecs[5]  = '{3, 2'b10, 1'b0, 1'b1};
    vecs[6]  = '{4, 2'b11, 1'b1, 1'b0};
    vecs[7]  = '{4, 2'b11, 1'b0, 1'b0};
    vecs[8]  = '{1, 2'b01, 1'b1, 1'b0};
    vecs[9]  = '{1, 2'b00, 1'b1, 1'b0};  // mode change alone, no pulse
    vecs[10] = '{1, 2'b10, 1'b0, 1'b1};
    vecs[11] = '{2, 2'b10, 1'b1, 1'b1};
    vecs[12] = '{2, 2'b00, 1'b0, 1'b0};

    bus.in_raw = '0;
    bus.mode   = '0;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(2);

    foreach (vecs[i]) begin
      drive(vecs[i].ch, vecs[i].mode, vecs[i].val, vecs[i].pul);
      wait_neg(8);
    end

    // Bounce on ch1: high 3, low 1, then high
    bus.mode[3:2] = 2'b10;
    bus.in_raw[1] = 1'b1;
    wait_neg(3);
    bus.in_raw[1] = 1'b0;
    wait_neg(1);
    drive(1, 2'b10, 1'b1, 1'b1);
    wait_neg(8);
    drive(1, 2'b10, 1'b0, 1'b1);
    wait_neg(8);

    // Simultaneous edges on ch2 and ch3
    drive(2, 2'b10, 1'b1, 1'b1);
    drive(3, 2'b10, 1'b1, 1'b1);
    wait_neg(8);
    drive(2, 2'b10, 1'b0, 1'b1);
    drive(3, 2'b10, 1'b0, 1'b1);
    wait_neg(8);

    // Hold-to-repeat on ch0: held 40 cycles after the press pulse
    drive(0, 2'b00, 1'b1, 1'b1);
    t = cyc + LAT;
`ifdef AUTOREPEAT_EN
    for (int d = t + RD; d <= t + 40 + LAT - 1; d += RP)
      q.push_back('{d, 0, 1'b1, 1'b1});
`endif
    while (cyc < t + 40) @(negedge clk);
    drive(0, 2'b00, 1'b0, 1'b0);
    wait_neg(10);

    // Mode change away from rise while held cancels repeating
    drive(0, 2'b00, 1'b1, 1'b1);
    wait_neg(10);
    bus.mode[1:0] = 2'b10;
    wait_neg(10);
    drive(0, 2'b10, 1'b0, 1'b1);
    wait_neg(8);

    // Reset mid-debounce with ch0 held high
    bus.mode[1:0] = 2'b10;
    bus.in_raw[0] = 1'b1;
    wait_neg(3);
    rst = 1'b1;
    wait_neg(3);
    rst = 1'b0;
    q.push_back('{cyc + LAT, 0, 1'b1, 1'b1});
    wait_neg(8);
    drive(0, 2'b10, 1'b0, 1'b1);
    wait_neg(8);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_pulse_array.md
# edge_pulse_array

Multi-channel input conditioner that generalises the single-input rising-edge pulse detector. Each channel has a 2-FF synchroniser, a debounce filter and a per-channel edge selector (rise, fall, both or disabled). Each accepted edge produces a one-cycle pulse. It sits between the raw push-buttons and switches and the alarm-clock control FSMs. Optional hold-to-repeat supports fast time setting.

## Interface
Parameters:
- CHANNELS, 5 — number of independent input channels (≥1).
- DEBOUNCE_CYCLES, 4 — consecutive synchronised cycles a new level must persist before acceptance (≥1).
- REPEAT_DELAY, 8 — cycles from the press pulse to the first repeat pulse (≥1; used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 4 — cycles between subsequent repeat pulses (≥1; used only with AUTOREPEAT_EN).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_raw  in  CHANNELS  asynchronous raw inputs, active-high.
- mode  in  2*CHANNELS  per-channel edge select, bits [2i+1:2i]: 00 rise, 01 fall, 10 both, 11 disabled.
- level  out  CHANNELS  debounced level per channel.
- pulse  out  CHANNELS  one-cycle edge/repeat pulse per channel.
- any_pulse  out  1  OR of all pulse bits.

## Operation
- Reset: sync FFs, level, debounce counters, pulse and repeat state all go to 0. any_pulse is 0.
- Synchroniser: two FFs per channel (s1, s2), reset to 0.
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s2 == level, the counter clears to 0.
  - If s2 != level and counter == DEBOUNCE_CYCLES-1, level <= s2 and the counter clears.
  - Otherwise the counter increments.
  - One cycle of s2 == level inside a run (a bounce) restarts the count.
- Edge pulse: registered, asserted on the same edge that level updates, only when mode matches:
  - 00: the 0→1 transition.
  - 01: the 1→0 transition.
  - 10: either transition.
  - 11: no pulses; level still tracks the input.
- mode is sampled combinationally on the updating edge. A mode change takes effect immediately and never generates a pulse by itself.
- any_pulse is a combinational OR of the registered pulse bits.
- Repeat FSM (per channel, AUTOREPEAT_EN only), states IDLE, DELAY, REPEAT:
  - IDLE→DELAY on a rise-edge pulse in mode 00; the repeat counter clears.
  - DELAY→REPEAT when the counter reaches REPEAT_DELAY-1; a pulse is emitted and the counter clears.
  - REPEAT: a pulse is emitted each time the counter reaches REPEAT_PERIOD-1.
  - Any state→IDLE when level goes to 0 or mode != 00. The pulse is suppressed on the edge that causes the exit.
- Reset mid-operation aborts every count and FSM. An input held high through reset is seen as a fresh 0→1 transition after reset.

## Timing
- Raw change captured by s1 at edge E: s2 changes at E+1, level updates and the pulse registers at E+1+DEBOUNCE_CYCLES. The pulse is high for exactly the following cycle. Total latency is DEBOUNCE_CYCLES+1 edges from s1 capture.
- Channels are fully independent. Simultaneous edges on several channels give simultaneous pulse bits and a single-cycle any_pulse.
- Repeat: press pulse at cycle t, repeats at t+REPEAT_DELAY, then t+REPEAT_DELAY+k·REPEAT_PERIOD for k≥1.
- Counters saturate at no point: every counter clears on its terminal count, so no wrap-around is possible.

## Configuration
- AUTOREPEAT_EN defined: the repeat FSM and counters are compiled in per channel, as above.
- AUTOREPEAT_EN undefined: no repeat logic is compiled. Each accepted edge gives exactly one pulse. REPEAT_DELAY and REPEAT_PERIOD are accepted but ignored.

## Structure
- Package edge_pkg holds:
  - Mode encodings EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_OFF=2'b11.
  - Repeat state encodings RPT_IDLE, RPT_DELAY, RPT_REPEAT.
- Sub-module edge_channel implements one channel (synchroniser, debounce, edge select, repeat FSM). The top instantiates CHANNELS copies in a generate loop and forms any_pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Clean rise: ch0 mode 00, in_raw[0] 0→1 before edge 10 → level[0] rises at edge 15, pulse[0] high only between edges 15 and 16, any_pulse matches.
- Bounce: in_raw[1] high 3 cycles, low 1, then high → no pulse until 4 consecutive high s2 samples. Exactly one pulse follows, 5 edges after the final s1 capture.
- Modes: ch2 mode 01 and ch3 mode 10 under a press-release sequence → ch2 pulses on release only, ch3 on both. ch4 mode 11 → level[4] toggles, pulse[4] stays 0.
- Autorepeat (macro on): ch0 held 40 cycles after the press pulse at t → pulses at t, t+8, t+12, t+16, …. Release → no pulse after level falls. With the macro off → the single pulse at t only.
- Reset: rst asserted mid-debounce with in_raw[0] high → all outputs 0 during reset. After rst deasserts at edge R → pulse[0] on edge R+6 (2 sync edges plus 4 debounce).
